// File: rtl/pipe_trace_buffer.sv
// Circular trace recorder for pipeline observation channels, with free-run and
// trigger-on-match capture and oldest-first readout once capture has ended.
module pipe_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 6,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     sample_en,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     trig_en,
    input  logic [DATA_W-1:0]        trig_value,
    input  logic [DATA_W-1:0]        trig_mask,
    input  logic [ADDR_W:0]          post_count,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     wrapped,
    output logic [ADDR_W:0]          count,
    output logic                     trig_hit,
    output logic [ADDR_W-1:0]        trig_idx
);

    localparam int              W        = NUM_CH * DATA_W;
    localparam logic [ADDR_W:0] FULL     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] MAX_POST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_POST, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              wrapped_reg, wrapped_next;
    logic              trig_hit_reg, trig_hit_next;
    logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;
    logic [ADDR_W-1:0] post_cnt_reg, post_cnt_next;

    logic [W-1:0]      mem [DEPTH];
    logic [W-1:0]      ram_q_reg;
    logic              rd_in_range_reg;
    logic              rd_valid_reg;

    logic              capturing;
    logic              wr_en;
    logic              match;
    logic [ADDR_W-1:0] post_init;
    logic [ADDR_W-1:0] oldest;
    logic [ADDR_W-1:0] rd_phys;

    assign capturing = (state_reg == S_PRE) || (state_reg == S_POST);
    assign wr_en     = capturing && sample_en && !arm;
    assign match     = trig_en && sample_en &&
                       (((ch_data[DATA_W-1:0] ^ trig_value) & trig_mask) == '0);
    // Clamp keeps the trigger sample from being overwritten by post samples.
    assign post_init = (post_count > MAX_POST) ? MAX_POST[ADDR_W-1:0]
                                               : post_count[ADDR_W-1:0];
    assign oldest    = wrapped_reg ? wr_ptr_reg : '0;
    assign rd_phys   = oldest + rd_addr;

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        count_next     = count_reg;
        wrapped_next   = wrapped_reg;
        trig_hit_next  = trig_hit_reg;
        trig_addr_next = trig_addr_reg;
        post_cnt_next  = post_cnt_reg;

        if (arm) begin
            state_next     = S_PRE;
            wr_ptr_next    = '0;
            count_next     = '0;
            wrapped_next   = 1'b0;
            trig_hit_next  = 1'b0;
            trig_addr_next = '0;
            post_cnt_next  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
                if (count_reg == FULL) begin
                    wrapped_next = 1'b1;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            unique case (state_reg)
                S_IDLE: ;
                S_PRE: begin
                    if (match) begin
                        trig_hit_next  = 1'b1;
                        trig_addr_next = wr_ptr_reg;
                        post_cnt_next  = post_init;
                        state_next     = (post_init == '0) ? S_DONE : S_POST;
                    end
                    if (stop) state_next = S_DONE;
                end
                S_POST: begin
                    if (sample_en) begin
                        post_cnt_next = post_cnt_reg - 1'b1;
                        if (post_cnt_reg == ADDR_W'(1)) state_next = S_DONE;
                    end
                    if (stop) state_next = S_DONE;
                end
                S_DONE: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            wrapped_reg     <= 1'b0;
            trig_hit_reg    <= 1'b0;
            trig_addr_reg   <= '0;
            post_cnt_reg    <= '0;
            rd_in_range_reg <= 1'b0;
            rd_valid_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            count_reg       <= count_next;
            wrapped_reg     <= wrapped_next;
            trig_hit_reg    <= trig_hit_next;
            trig_addr_reg   <= trig_addr_next;
            post_cnt_reg    <= post_cnt_next;
            rd_in_range_reg <= rd_en && ({1'b0, rd_addr} < count_reg);
            rd_valid_reg    <= rd_en;
        end
    end

    // Unreset RAM with registered read; read-before-write falls out of NBA ordering.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= ch_data;
        if (rd_en) ram_q_reg <= mem[rd_phys];
    end

    assign rd_data  = rd_in_range_reg ? ram_q_reg : '0;
    assign rd_valid = rd_valid_reg;
    assign busy     = capturing;
    assign done     = (state_reg == S_DONE);
    assign wrapped  = wrapped_reg;
    assign count    = count_reg;
    assign trig_hit = trig_hit_reg;
    assign trig_idx = (done && trig_hit_reg) ? (trig_addr_reg - oldest) : '0;

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Parametrised, synthesizable trace recorder for the pipelined CPU.
- Captures up to NUM_CH pipeline observation channels (PC, IF/ID instruction, EXE/MEM/WB ALU results) into a circular buffer on each sample cycle.
- Supports a free-run mode and a trigger-on-match mode with a post-trigger sample count.
- Allows oldest-first readout after capture stops, replacing waveform-only inspection on hardware.

Parameters:
- DATA_W, 32: width of one channel.
- NUM_CH, 6: number of channels; channel 0 is the trigger channel.
- DEPTH, 16: entries in the buffer; power of two, at least 2.
- ADDR_W, 4: log2(DEPTH).

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Arm  in  1  start or restart capture, sampled high for one cycle.
- Stop  in  1  force capture end.
- Sample_En  in  1  record Ch_Data this cycle.
- Ch_Data  in  NUM_CH*DATA_W  packed channels; channel 0 occupies bits [DATA_W-1:0].
- Trig_En  in  1  1 = trigger mode, 0 = free-run.
- Trig_Value  in  DATA_W  compare value for channel 0.
- Trig_Mask  in  DATA_W  compare mask; a 1 bit means that bit is compared.
- Post_Count  in  ADDR_W+1  samples kept after the trigger sample.
- Rd_En  in  1  read request.
- Rd_Addr  in  ADDR_W  logical index; 0 is the oldest entry.
- Rd_Data  out  NUM_CH*DATA_W  read data.
- Rd_Valid  out  1  Rd_Data valid.
- Busy  out  1  state is PRE or POST.
- Done  out  1  state is DONE.
- Wrapped  out  1  buffer has overwritten its oldest entry.
- Count  out  ADDR_W+1  valid entries, range 0..DEPTH.
- Trig_Hit  out  1  a trigger occurred in this capture.
- Trig_Idx  out  ADDR_W  logical index of the trigger sample.

Behaviour:
- Reset: Resetn low asynchronously forces state IDLE and clears all outputs, wr_ptr and the post-trigger counter to 0. Buffer RAM is not reset. Reset during PRE or POST aborts the capture with no partial Done.
- States: IDLE, PRE, POST, DONE.
- IDLE: nothing is written. Arm -> PRE.
- Entering PRE from any state on Arm: wr_ptr=0, Count=0, Wrapped=0, Trig_Hit=0, Trig_Idx=0.
- Arm has priority over Stop and over every other transition in the same cycle.
- Write rule (PRE and POST only):
  - A Sample_En cycle writes Ch_Data to mem[wr_ptr]; wr_ptr increments mod DEPTH.
  - Count increments, saturating at DEPTH.
  - Wrapped sets when a write lands while Count==DEPTH.
- Trigger match: Trig_En & (((Ch_Data[ch0] ^ Trig_Value) & Trig_Mask) == 0) & Sample_En.
- PRE, on match:
  - The trigger sample is written; Trig_Hit=1; trigger physical address = wr_ptr before increment.
  - Post counter = min(Post_Count, DEPTH-1). The clamp guarantees the trigger sample survives.
  - Post counter 0 -> DONE; otherwise -> POST.
- POST: each written sample decrements the post counter; the write that brings it to 0 -> DONE.
- Stop in PRE or POST -> DONE. Any sample written in that same cycle is kept. Stop in IDLE or DONE is ignored.
- Done rises the cycle after the final write. Busy and Done are never both 1.
- Oldest physical address = Wrapped ? wr_ptr : 0.
- Trig_Idx = (trigger physical address - oldest) mod DEPTH. Valid in DONE when Trig_Hit=1, otherwise 0.
- Read path:
  - Any state accepts Rd_En. Data are meaningful only in DONE.
  - Physical address = (oldest + Rd_Addr) mod DEPTH.
  - Rd_Data is registered and appears 1 cycle after Rd_En, with Rd_Valid=1 for that cycle only.
  - Rd_Addr >= Count -> Rd_Data = 0, Rd_Valid still 1.
  - Back-to-back reads give one result per cycle.
  - A read in the same cycle as a write returns the old RAM contents (read-before-write).
- Gaps where Sample_En is low are not recorded and do not advance wr_ptr or the post counter.
- Free-run (Trig_En=0) only ends on Stop.
- A match while already in POST is ignored.

Test Plan:
All scenarios use DEPTH=16, NUM_CH=6, DATA_W=32, and channel 0 value = sample number k unless stated.
1. Free-run: Trig_En=0, Arm, samples k=0..9, Stop -> Done=1, Count=10, Wrapped=0. Rd_Addr 0..9 return ch0 0..9 one cycle after Rd_En. Rd_Addr=10 returns 0 with Rd_Valid=1.
2. Wrap: samples k=0..19, then Stop -> Count=16, Wrapped=1; Rd_Addr=0 ch0=4, Rd_Addr=15 ch0=19.
3. Trigger:
   - Setup: ch0=4k, Trig_Value=0x40, Trig_Mask=0xFFFFFFFF, Post_Count=3, samples k=0..30.
   - Trigger at k=16; Done rises the cycle after k=19; later samples are ignored.
   - Expected: Count=16, Trig_Hit=1, Trig_Idx=12, Rd_Addr=12 returns ch0=0x40.
4. Clamp and mask:
   - Post_Count=20 with trigger at k=5 (masked compare, Trig_Mask=0x0F, Trig_Value=0x05) -> clamped to 15 post samples, Trig_Idx=0, Rd_Addr=0 returns ch0=5.
   - Post_Count=0 -> Done the cycle after the trigger sample.
5. Gaps and simultaneous events:
   - Sample_En toggling 1/0 over 8 cycles -> Count=4.
   - Arm and Stop high in the same cycle during POST -> state PRE, Count=0, Busy=1.
6. Reset mid-capture: Resetn low during POST -> immediately Busy=0, Done=0, Count=0, Trig_Hit=0. After release, Arm restarts a clean capture that matches scenario 1.
